// File: rtl/ch_sweep_scheduler.sv
// Frequency-sweep sequencer: writes each 48-bit sweep point as a 6-byte LSB-first
// burst on the channel config bus, sharing the bus with host writes (host first).
module ch_sweep_scheduler #(
    parameter logic [7:0] FREQ_ADDR_BASE = 8'h03,
    parameter int         DWELL_W        = 24
) (
    input  logic               CLK_LOW,
    input  logic               RST,
    input  logic               SWEEP_START,
    input  logic               SWEEP_STOP,
    input  logic               SWEEP_MODE,
    input  logic [47:0]        START_FREQ_INC,
    input  logic [47:0]        STOP_FREQ_INC,
    input  logic [47:0]        STEP_FREQ_INC,
    input  logic [DWELL_W-1:0] DWELL_CNT,
    input  logic               CH_LOAD_PROTECT_STATE,
    input  logic               HOST_WE,
    input  logic [7:0]         HOST_ADDR,
    input  logic [7:0]         HOST_DATA,
    output logic               CH_CONFIG_WE,
    output logic [7:0]         CH_CONFIG_ADDR,
    output logic [7:0]         CH_CONFIG_DATA,
    output logic               SWEEP_BUSY,
    output logic               SWEEP_DONE,
    output logic [47:0]        CUR_FREQ_INC
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_DWELL, S_STEP, S_DONE} state_t;

    state_t             state, state_d;
    logic [2:0]         idx, idx_d;
    logic [DWELL_W-1:0] cnt, cnt_d;
    logic [47:0]        cur_d;
    logic               abort_pend, abort_pend_d;
    logic               latch;

    logic [47:0]        start_l, stop_l, step_l;
    logic [DWELL_W-1:0] dwell_l, dwell_last;
    logic               mode_l;

    logic               abort;
    logic [48:0]        sum;
    logic [5:0]         bsel;
    logic               we_d;
    logic [7:0]         addr_d, data_d;

    assign abort      = SWEEP_STOP | CH_LOAD_PROTECT_STATE;
    assign sum        = {1'b0, CUR_FREQ_INC} + {1'b0, step_l};
    assign dwell_last = (dwell_l == '0) ? '0 : dwell_l - 1'b1;
    assign bsel       = {idx, 3'b000};

    always_comb begin
        state_d      = state;
        idx_d        = idx;
        cnt_d        = cnt;
        cur_d        = CUR_FREQ_INC;
        abort_pend_d = abort_pend;
        latch        = 1'b0;
        we_d         = 1'b0;
        addr_d       = '0;
        data_d       = '0;

        case (state)
            S_IDLE: begin
                if (SWEEP_START && !abort) begin
                    state_d      = S_WRITE;
                    cur_d        = START_FREQ_INC;
                    idx_d        = '0;
                    abort_pend_d = 1'b0;
                    latch        = 1'b1;
                end
            end
            S_WRITE: begin
                // An abort only takes effect once the burst is complete, so the
                // channel never commits a half-updated frequency.
                abort_pend_d = abort_pend | abort;
                if (!HOST_WE) begin
                    if (idx == 3'd5) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = abort_pend_d ? S_IDLE : S_DWELL;
                    end else begin
                        idx_d = idx + 3'd1;
                    end
                end
            end
            S_DWELL: begin
                if (abort)
                    state_d = S_IDLE;
                else if (cnt == dwell_last)
                    state_d = S_STEP;
                else
                    cnt_d = cnt + 1'b1;
            end
            S_STEP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!sum[48] && sum[47:0] <= stop_l) begin
                    cur_d   = sum[47:0];
                    state_d = S_WRITE;
                end else if (mode_l) begin
                    cur_d   = start_l;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (HOST_WE) begin
            we_d   = 1'b1;
            addr_d = HOST_ADDR;
            data_d = HOST_DATA;
        end else if (state == S_WRITE) begin
            we_d   = 1'b1;
            addr_d = FREQ_ADDR_BASE + {5'd0, idx};
            data_d = CUR_FREQ_INC[bsel +: 8];
        end
    end

    always_ff @(posedge CLK_LOW) begin
        if (RST) begin
            state          <= S_IDLE;
            idx            <= '0;
            cnt            <= '0;
            abort_pend     <= 1'b0;
            start_l        <= '0;
            stop_l         <= '0;
            step_l         <= '0;
            dwell_l        <= '0;
            mode_l         <= 1'b0;
            CUR_FREQ_INC   <= '0;
            CH_CONFIG_WE   <= 1'b0;
            CH_CONFIG_ADDR <= '0;
            CH_CONFIG_DATA <= '0;
            SWEEP_BUSY     <= 1'b0;
            SWEEP_DONE     <= 1'b0;
        end else begin
            state          <= state_d;
            idx            <= idx_d;
            cnt            <= cnt_d;
            abort_pend     <= abort_pend_d;
            CUR_FREQ_INC   <= cur_d;
            CH_CONFIG_WE   <= we_d;
            CH_CONFIG_ADDR <= addr_d;
            CH_CONFIG_DATA <= data_d;
            SWEEP_BUSY     <= (state_d != S_IDLE);
            SWEEP_DONE     <= (state_d == S_DONE);
            if (latch) begin
                start_l <= START_FREQ_INC;
                stop_l  <= STOP_FREQ_INC;
                step_l  <= STEP_FREQ_INC;
                dwell_l <= DWELL_CNT;
                mode_l  <= SWEEP_MODE;
            end
        end
    end

endmodule
